// File: rtl/parser_pkg.sv
// Shared UART parser definitions: message types, framing characters, opcodes
// and the structural frame lengths used by the message assembler.
package parser_pkg;

  typedef enum logic [2:0] {
    MSG_NONE            = 3'd0,
    MSG_RGF_READ        = 3'd1,
    MSG_RGF_WRITE       = 3'd2,
    MSG_SINGLE_PIXEL_WR = 3'd3,
    MSG_START_BURST_RD  = 3'd4,
    MSG_START_BURST_WR  = 3'd5,
    MSG_BURST_PIXEL_WR  = 3'd6
  } msg_type_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_e;

  localparam logic [7:0] CHAR_OPEN  = 8'h7B;
  localparam logic [7:0] CHAR_CLOSE = 8'h7D;
  localparam logic [7:0] CHAR_COMMA = 8'h2C;
  localparam logic [7:0] OP_W       = 8'h57;
  localparam logic [7:0] OP_R       = 8'h52;
  localparam logic [7:0] OP_I       = 8'h49;
  localparam logic [7:0] CHAR_V     = 8'h56;
  localparam logic [7:0] CHAR_P     = 8'h50;

  localparam int LEN_RGF_READ     = 6;
  localparam int LEN_SINGLE_PIXEL = 11;
  localparam int LEN_FULL         = 16;

  // Frames are tracked by the index of their final byte so it fits in 4 bits.
  function automatic logic [3:0] last_index(input int len);
    return 4'(len - 1);
  endfunction

endpackage

// File: rtl/uart_msg_timeout.sv
// Inter-byte idle counter: cleared by kick or while disabled, raises expire
// on the cycle the idle count would reach TIMEOUT_CYCLES.
module uart_msg_timeout #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expire
);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  // A kick in the expiry cycle suppresses the expiry.
  assign expire = enable && !kick && (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (kick || !enable || expire) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_msg_assembler.sv
// Frames UART RX bytes into messages and classifies them structurally.
// Optional inter-byte timeout abort enabled by `define UART_MSG_ASM_TIMEOUT_EN.
module uart_msg_assembler
  import parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  input  logic         burst_on,
  output logic [127:0] msg_data,
  output logic         msg_valid,
  output msg_type_e    msg_type,
  output logic         frame_err,
  output logic         busy
);

  asm_state_e   state_q, state_d;
  logic [127:0] buf_q, buf_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   last_q, last_d;
  logic         mode_burst_q, mode_burst_d;
  logic [7:0]   op_q, op_d;
  msg_type_e    type_q, type_d;
  logic         msg_valid_q, msg_valid_d;
  msg_type_e    msg_type_q, msg_type_d;
  logic         frame_err_q, frame_err_d;

  logic         tmo_expire;
  logic         abort;
  logic [3:0]   last_eff;
  msg_type_e    type_eff;

`ifdef UART_MSG_ASM_TIMEOUT_EN
  uart_msg_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TMO_W         (TMO_W)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .enable(state_q == ST_COLLECT),
    .kick  (rx_valid),
    .expire(tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    mode_burst_d = mode_burst_q;
    op_d         = op_q;
    type_d       = type_q;
    msg_valid_d  = 1'b0;
    msg_type_d   = msg_type_q;
    frame_err_d  = 1'b0;
    abort        = 1'b0;
    last_eff     = last_q;
    type_eff     = type_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_byte == CHAR_OPEN) begin
          buf_d        = {120'b0, CHAR_OPEN};
          cnt_d        = 4'd1;
          mode_burst_d = burst_on;
          op_d         = 8'h00;
          last_d       = last_index(LEN_FULL);
          type_d       = burst_on ? MSG_BURST_PIXEL_WR : MSG_NONE;
          state_d      = ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (rx_valid) begin
          buf_d[{cnt_q, 3'b000} +: 8] = rx_byte;
          cnt_d = cnt_q + 4'd1;

          // Length and type are settled by the opcode and delimiter bytes;
          // burst payloads are never inspected.
          if (!mode_burst_q) begin
            if (cnt_q == 4'd1) begin
              op_d = rx_byte;
              if (rx_byte == OP_I) begin
                type_eff = MSG_START_BURST_WR;
              end else if (rx_byte != OP_R && rx_byte != OP_W) begin
                abort = 1'b1;
              end
            end else if (cnt_q == 4'd5 && op_q == OP_R) begin
              if (rx_byte == CHAR_CLOSE) begin
                last_eff = last_index(LEN_RGF_READ);
                type_eff = MSG_RGF_READ;
              end else if (rx_byte == CHAR_COMMA) begin
                type_eff = MSG_START_BURST_RD;
              end else begin
                abort = 1'b1;
              end
            end else if (cnt_q == 4'd6 && op_q == OP_W) begin
              if (rx_byte == CHAR_V) begin
                type_eff = MSG_RGF_WRITE;
              end else if (rx_byte == CHAR_P) begin
                last_eff = last_index(LEN_SINGLE_PIXEL);
                type_eff = MSG_SINGLE_PIXEL_WR;
              end else begin
                abort = 1'b1;
              end
            end
          end

          last_d = last_eff;
          type_d = type_eff;

          if (abort) begin
            state_d     = ST_IDLE;
            cnt_d       = 4'd0;
            frame_err_d = 1'b1;
          end else if (cnt_q == last_eff) begin
            state_d     = ST_IDLE;
            cnt_d       = 4'd0;
            msg_valid_d = 1'b1;
            msg_type_d  = type_eff;
          end
        end else if (tmo_expire) begin
          state_d     = ST_IDLE;
          cnt_d       = 4'd0;
          frame_err_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      cnt_q        <= 4'd0;
      last_q       <= 4'd0;
      mode_burst_q <= 1'b0;
      op_q         <= 8'h00;
      type_q       <= MSG_NONE;
      msg_valid_q  <= 1'b0;
      msg_type_q   <= MSG_NONE;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      mode_burst_q <= mode_burst_d;
      op_q         <= op_d;
      type_q       <= type_d;
      msg_valid_q  <= msg_valid_d;
      msg_type_q   <= msg_type_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign msg_data  = buf_q;
  assign msg_valid = msg_valid_q;
  assign msg_type  = msg_type_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_uart_msg_assembler.sv
// Scoreboard bench for uart_msg_assembler: directed frames push expectations,
// a negedge monitor pops and compares on every msg_valid / frame_err pulse.
module tb_uart_msg_assembler;
  import parser_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic         burst_on;
  logic [127:0] msg_data;
  logic         msg_valid;
  msg_type_e    msg_type;
  logic         frame_err;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int lastDriveCycle = 0;

  typedef struct {
    bit           isErr;
    msg_type_e    mtype;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  uart_msg_assembler #(.TIMEOUT_CYCLES(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .burst_on (burst_on),
    .msg_data (msg_data),
    .msg_valid(msg_valid),
    .msg_type (msg_type),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every output event must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (msg_valid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_msg_valid: got type %0d, expected no event", msg_type);
        end else begin
          monE = expQ.pop_front();
          checkOutput("event_kind_msg", 128'd0, 128'(monE.isErr));
          if (!monE.isErr) begin
            checkOutput("msg_type", 128'(msg_type), 128'(monE.mtype));
            checkOutput("msg_data", msg_data, monE.data);
            if (monE.due >= 0) checkOutput("msg_latency", 128'(cycleCount), 128'(monE.due));
          end
        end
      end
      if (frame_err) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_frame_err: got pulse, expected no event");
        end else begin
          monE = expQ.pop_front();
          checkOutput("event_kind_err", 128'd1, 128'(monE.isErr));
          if (monE.due >= 0) checkOutput("err_latency", 128'(cycleCount), 128'(monE.due));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    lastDriveCycle = cycleCount;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_byte  = 8'h00;
    end
  endtask

  // vec holds the frame in msg_data layout, so it is also the expected buffer.
  task automatic sendFrame(input logic [127:0] vec, input int n, input bit expErr,
                           input msg_type_e t, input bit dropBurst);
    for (int i = 0; i < n; i++) begin
      applyStimulus(vec[8*i +: 8]);
      if (i == 1 && dropBurst) burst_on = 1'b0;
      if (i == n - 1) expQ.push_back('{expErr, t, vec, lastDriveCycle + 1});
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_msg_data"},  msg_data, 128'd0);
    checkOutput({tag, "_msg_valid"}, 128'(msg_valid), 128'd0);
    checkOutput({tag, "_msg_type"},  128'(msg_type), 128'(MSG_NONE));
    checkOutput({tag, "_frame_err"}, 128'(frame_err), 128'd0);
    checkOutput({tag, "_busy"},      128'(busy), 128'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    burst_on = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    idle(2);

    $display("[TB] RGF read frame");
    sendFrame(128'h7D_10_00_05_52_7B, 6, 1'b0, MSG_RGF_READ, 1'b0);
    idle(3);

    $display("[TB] RGF write and single pixel frames");
    sendFrame(128'h7D_17_16_15_14_13_12_11_10_56_04_03_02_01_57_7B, 16, 1'b0, MSG_RGF_WRITE, 1'b0);
    idle(2);
    sendFrame(128'h7D_33_22_11_50_03_02_01_00_57_7B, 11, 1'b0, MSG_SINGLE_PIXEL_WR, 1'b0);
    idle(2);
    checkOutput("pixel_rgb", 128'(msg_data[79:56]), 128'h332211);

    $display("[TB] burst frame with embedded delimiters");
    burst_on = 1'b1;
    sendFrame(128'h0F_7B_2C_0C_0B_0A_7D_08_07_06_05_04_7D_02_01_7B, 16, 1'b0, MSG_BURST_PIXEL_WR, 1'b1);
    idle(2);

    $display("[TB] bad opcode abort then recovery");
    sendFrame(128'h41_7B, 2, 1'b1, MSG_NONE, 1'b0);
    idle(2);
    checkOutput("type_hold_after_abort", 128'(msg_type), 128'(MSG_BURST_PIXEL_WR));
    checkOutput("busy_after_abort", 128'(busy), 128'd0);
    sendFrame(128'h7D_10_00_05_52_7B, 6, 1'b0, MSG_RGF_READ, 1'b0);
    idle(2);

    $display("[TB] junk bytes, back-to-back frames");
    applyStimulus(8'h00);
    applyStimulus(8'h2C);
    applyStimulus(8'h7D);
    sendFrame(128'h7D_44_33_22_52_7B, 6, 1'b0, MSG_RGF_READ, 1'b0);
    sendFrame(128'h29_28_27_26_25_24_23_22_21_20_2C_10_00_05_52_7B, 16, 1'b0, MSG_START_BURST_RD, 1'b0);
    sendFrame(128'h0F_0E_0D_0C_0B_0A_09_08_07_06_7D_03_02_01_49_7B, 16, 1'b0, MSG_START_BURST_WR, 1'b0);
    idle(2);

    $display("[TB] delimiter aborts");
    sendFrame(128'h55_03_02_01_52_7B, 6, 1'b1, MSG_NONE, 1'b0);
    idle(2);
    sendFrame(128'h41_04_03_02_01_57_7B, 7, 1'b1, MSG_NONE, 1'b0);
    idle(2);
    checkOutput("type_hold_after_w_abort", 128'(msg_type), 128'(MSG_START_BURST_WR));

    $display("[TB] reset mid-frame");
    applyStimulus(8'h7B);
    applyStimulus(8'h52);
    applyStimulus(8'h05);
`ifdef UART_MSG_ASM_TIMEOUT_EN
    idle(3);
`else
    idle(30);
`endif
    checkOutput("busy_mid_frame", 128'(busy), 128'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues("midreset");
    rst = 1'b0;
    idle(2);
    sendFrame(128'h7D_10_00_05_52_7B, 6, 1'b0, MSG_RGF_READ, 1'b0);
    idle(2);

`ifdef UART_MSG_ASM_TIMEOUT_EN
    $display("[TB] inter-byte timeout");
    applyStimulus(8'h7B);
    applyStimulus(8'h52);
    expQ.push_back('{1'b1, MSG_NONE, 128'd0, lastDriveCycle + 21});
    idle(25);
    checkOutput("busy_after_timeout", 128'(busy), 128'd0);
    checkOutput("type_hold_after_timeout", 128'(msg_type), 128'(MSG_RGF_READ));
`endif

    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d outstanding events, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/uart_msg_assembler.md
Name: uart_msg_assembler

Overview:
- Frames the UART receiver's byte stream into messages and classifies each by structure only.
- Sits between the UART RX byte deserializer and uart_classifier. Drives msg_data, msg_valid and msg_type; takes burst_on back from the classifier.
- Finds frame length and type from opcode and delimiter positions. Full field validation is left to the classifier.

Parameters:
- TIMEOUT_CYCLES, 100000, maximum idle cycles between bytes inside a frame before abort.
- TMO_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_byte  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- burst_on  in  1  burst pixel mode active (from classifier)
- msg_data  out  128  assembled frame; byte i at [8i+7:8i]
- msg_valid  out  1  one-cycle pulse, frame complete
- msg_type  out  msg_type_e  structural type of the last completed frame
- frame_err  out  1  one-cycle pulse, frame aborted
- busy  out  1  high while in COLLECT

Behaviour:
- Reset values: msg_data=0, msg_valid=0, msg_type=MSG_NONE, frame_err=0, busy=0, byte count=0, FSM=IDLE. Reset mid-frame discards the partial frame with no pulse.
- FSM IDLE:
  - rx_valid with rx_byte==0x7B ('{'): buffer <= {120'b0, 8'h7B}, cnt <= 1, mode_burst <= burst_on, go COLLECT.
  - Any other byte is dropped silently.
- burst_on is sampled only at byte0; changes mid-frame are ignored.
- FSM COLLECT: each rx_valid writes rx_byte to buffer byte[cnt], then cnt++.
- Burst mode (mode_burst=1):
  - Frame length is fixed at 16; type MSG_BURST_PIXEL_WR.
  - No byte after byte0 is inspected; payload bytes may equal '{', '}' or ','.
- Non-burst mode, decisions made when the named byte is accepted:
  - byte1: 'W'(0x57), 'R'(0x52), 'I'(0x49) accepted. Anything else → abort.
  - 'R', byte5=='}' (0x7D): length 6, MSG_RGF_READ.
  - 'R', byte5==',' (0x2C): length 16, MSG_START_BURST_RD.
  - 'R', any other byte5 → abort.
  - 'W', byte6=='V'(0x56): length 16, MSG_RGF_WRITE.
  - 'W', byte6=='P'(0x50): length 11 (byte10 is '}', not checked here), MSG_SINGLE_PIXEL_WR.
  - 'W', any other byte6 → abort.
  - 'I': length 16, MSG_START_BURST_WR.
- Completion, when the byte with index length-1 is accepted:
  - FSM → IDLE.
  - Next cycle: msg_valid=1 for exactly one cycle, msg_type updated in the same cycle.
  - Latency: last rx_valid edge + 1 cycle.
- Hold rules:
  - msg_data and msg_type stay stable until the next '{' is accepted.
  - A '{' arriving in the msg_valid cycle is legal. The consumer samples the old buffer at that same edge.
- Abort: FSM → IDLE, frame_err pulses one cycle. msg_valid, msg_type and msg_data are not updated except for bytes already written; consumers ignore msg_data without msg_valid.
- Unwritten bytes in short frames read as 0x00.
- Only one rx_valid is accepted per cycle; there is no backpressure.

Optional Feature:
- UART_MSG_ASM_TIMEOUT_EN defined:
  - Counter resets on every accepted byte and increments in COLLECT.
  - When it reaches TIMEOUT_CYCLES: abort with frame_err.
  - A byte arriving in the expiry cycle wins: it is accepted and the counter resets.
- Undefined: no counter; a partial frame waits indefinitely.

Decomposition:
- parser_pkg already holds msg_type_e, CHAR_OPEN, CHAR_CLOSE, CHAR_COMMA, OP_W, OP_R, OP_I, CHAR_V, CHAR_P; reuse these.
- Add to parser_pkg: LEN_RGF_READ=6, LEN_SINGLE_PIXEL=11, LEN_FULL=16.
- One sub-module, uart_msg_timeout: counter with kick/expire, instantiated only under UART_MSG_ASM_TIMEOUT_EN.

Test Plan:
- {R,0x05,0x00,0x10,} bytes 7B 52 05 00 10 7D → msg_valid 1 cycle after last byte; msg_type=MSG_RGF_READ; msg_data[47:0]=0x7D1000055 27B; bytes 6-15 = 0.
- 16-byte W frame with byte6=0x56 → MSG_RGF_WRITE. 11-byte W frame with byte6=0x50, R,G,B=0x11,0x22,0x33 → MSG_SINGLE_PIXEL_WR; msg_data[79:56]=0x332211.
- burst_on=1, frame 7B followed by 15 bytes containing 0x7D at positions 3 and 9 → no early termination; MSG_BURST_PIXEL_WR after the 16th byte.
- 7B then 0x41 ('A') → frame_err pulse, no msg_valid. A following valid R frame completes normally.
- Junk bytes 0x00, 0x2C before '{' are ignored. A '{' in the msg_valid cycle starts a new frame; the classifier still captures the previous frame.
- With UART_MSG_ASM_TIMEOUT_EN and TIMEOUT_CYCLES=20: send 7B 52, then 20 idle cycles → frame_err, busy=0. Reset asserted mid-frame → all outputs return to reset values.
